// File: rtl/go_link_pkg.sv
// Shared types and constants for the move-exchange link controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
// Contents: move_t byte type, reserved ACK code, send-FSM state encoding, ACK decode helper.
package go_link_pkg;

    typedef logic [7:0] move_t;

    // Reserved code that no legal move encoding can take.
    localparam move_t ACK_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        ERR
    } link_state_t;

    function automatic logic is_ack(input move_t b);
        return b == ACK_BYTE;
    endfunction

endpackage

// File: rtl/link_timer.sv
// Down-counter: loads a value and counts to zero; expired is high while the count is zero.
// Latency: load takes effect on the next clock edge; expired is combinational from the count register.
// Backpressure: none, free-running once loaded; a new load restarts it at any time.
// Ports: clk_in/rst_n_in clock and async active-low reset, load/load_val restart, expired count==0.
module link_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             expired
);

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - WIDTH'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/move_link_ctrl.sv
// Reliable move exchange with the peer: send/ACK/retransmit for local moves, ACK+dedupe for peer moves.
// Latency: tx_trigger is registered, 1 cycle after local_move_valid or rx_ready at the earliest.
// Backpressure: one tx byte per BYTE_CYC; ACK beats move; one pending ACK is held, more collapse into it.
// Ports: clk_in/rst_n_in; game_fsm side local_move_valid/local_move/peer_turn -> local_busy/local_done/
//        link_err/retry_count/peer_move_valid/peer_move; UART side tx_trigger/tx_data, rx_ready/rx_data.
module move_link_ctrl
    import go_link_pkg::*;
#(
    parameter int BYTE_CYC        = 67_710,
    parameter int ACK_TIMEOUT_CYC = 6_500_000,
    parameter int MAX_RETRIES     = 3
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       local_move_valid,
    input  move_t      local_move,
    input  logic       peer_turn,
    output logic       local_busy,
    output logic       local_done,
    output logic       link_err,
    output logic [1:0] retry_count,
    output logic       tx_trigger,
    output move_t      tx_data,
    input  logic       rx_ready,
    input  move_t      rx_data,
    output logic       peer_move_valid,
    output move_t      peer_move
);

    localparam int         HOLD_W = $clog2(BYTE_CYC + 1);
    localparam int         ACK_W  = $clog2(ACK_TIMEOUT_CYC + 1);
    localparam logic [1:0] MAX_R  = 2'(MAX_RETRIES);

    link_state_t state, state_nxt;
    move_t       move_q, move_nxt, move_byte;
    logic [1:0]  retry_nxt;
    logic        err_nxt, done_nxt;
    logic        ack_pend, ack_arm, delivered;
    logic        hold_free, ack_zero, ack_tmr_load;
    logic        rx_ack, rx_move, ack_req, deliver, timeout, retry_ok;
    logic        move_req, move_fire, ack_fire;

    // Byte hold: line is busy for BYTE_CYC cycles after every trigger.
    link_timer #(.WIDTH(HOLD_W)) u_hold_tmr (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .load     (ack_fire | move_fire),
        .load_val (HOLD_W'(BYTE_CYC - 1)),
        .expired  (hold_free)
    );

    // ACK timeout: armed by a move trigger, started only once that move byte has left the line.
    link_timer #(.WIDTH(ACK_W)) u_ack_tmr (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .load     (ack_tmr_load),
        .load_val (ACK_W'(ACK_TIMEOUT_CYC - 1)),
        .expired  (ack_zero)
    );

    assign rx_ack       = rx_ready & is_ack(rx_data);
    assign rx_move      = rx_ready & ~is_ack(rx_data);
    assign ack_req      = ack_pend | rx_move;
    assign deliver      = rx_move & peer_turn & ~delivered;
    assign ack_tmr_load = ack_arm & hold_free;
    // While armed the timer still holds a stale zero, so it cannot signal a timeout yet.
    assign timeout      = (state == WAIT_ACK) & ~ack_arm & ack_zero;
    assign retry_ok     = retry_count < MAX_R;
    assign ack_fire     = hold_free & ack_req;
    assign local_busy   = (state == SEND) | (state == WAIT_ACK);

    always_comb begin
        state_nxt = state;
        move_nxt  = move_q;
        retry_nxt = retry_count;
        err_nxt   = link_err;
        done_nxt  = 1'b0;
        move_req  = 1'b0;
        move_byte = move_q;
        case (state)
            IDLE, ERR: begin
                // Allow the new move straight onto a free line in the request cycle.
                move_byte = local_move;
                move_req  = local_move_valid;
                if (local_move_valid) begin
                    move_nxt  = local_move;
                    retry_nxt = '0;
                    err_nxt   = 1'b0;
                    state_nxt = SEND;
                end
            end
            SEND: move_req = 1'b1;
            WAIT_ACK: begin
                // An ACK landing on the expiry cycle wins over the timeout.
                if (rx_ack) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end else if (timeout) begin
                    if (retry_ok) begin
                        retry_nxt = retry_count + 2'd1;
                        state_nxt = SEND;
                        move_req  = 1'b1;
                    end else begin
                        state_nxt = ERR;
                        err_nxt   = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        move_fire = hold_free & ~ack_req & move_req;
        if (move_fire) begin
            state_nxt = WAIT_ACK;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= IDLE;
            move_q          <= '0;
            retry_count     <= '0;
            link_err        <= 1'b0;
            local_done      <= 1'b0;
            ack_pend        <= 1'b0;
            ack_arm         <= 1'b0;
            delivered       <= 1'b0;
            tx_trigger      <= 1'b0;
            tx_data         <= '0;
            peer_move_valid <= 1'b0;
            peer_move       <= '0;
        end else begin
            state       <= state_nxt;
            move_q      <= move_nxt;
            retry_count <= retry_nxt;
            link_err    <= err_nxt;
            local_done  <= done_nxt;
            // A single pending flag: moves arriving while an ACK waits share that one ACK.
            ack_pend    <= ack_fire ? 1'b0 : (ack_pend | rx_move);
            ack_arm     <= move_fire | (ack_arm & ~hold_free);
            delivered   <= peer_turn & (delivered | rx_move);
            tx_trigger  <= ack_fire | move_fire;
            if (ack_fire) begin
                tx_data <= ACK_BYTE;
            end else if (move_fire) begin
                tx_data <= move_byte;
            end
            peer_move_valid <= deliver;
            if (deliver) begin
                peer_move <= rx_data;
            end
        end
    end

endmodule

// File: tb/tb_move_link_ctrl.sv
// Directed bench for move_link_ctrl with short timers (BYTE_CYC=20, ACK_TIMEOUT_CYC=100, MAX_RETRIES=2).
// Latency: inputs driven on the falling edge, outputs sampled on the falling edge.
// Backpressure: n/a; tx triggers are logged with their cycle number for spacing checks.
module tb_move_link_ctrl;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       local_move_valid = 1'b0;
    logic [7:0] local_move = 8'h00;
    logic       peer_turn = 1'b0;
    logic       local_busy, local_done, link_err, tx_trigger, peer_move_valid;
    logic [1:0] retry_count;
    logic [7:0] tx_data, peer_move;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data = 8'h00;

    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    int         pmv_cnt = 0;
    int         trig_cyc[$];
    logic [7:0] trig_dat[$];

    move_link_ctrl #(.BYTE_CYC(20), .ACK_TIMEOUT_CYC(100), .MAX_RETRIES(2)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .local_move_valid(local_move_valid), .local_move(local_move), .peer_turn(peer_turn),
        .local_busy(local_busy), .local_done(local_done), .link_err(link_err), .retry_count(retry_count),
        .tx_trigger(tx_trigger), .tx_data(tx_data), .rx_ready(rx_ready), .rx_data(rx_data),
        .peer_move_valid(peer_move_valid), .peer_move(peer_move)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc = cyc + 1;

    always @(negedge clk_in) begin
        if (rst_n_in && tx_trigger) begin
            trig_cyc.push_back(cyc);
            trig_dat.push_back(tx_data);
        end
        if (rst_n_in && peer_move_valid) pmv_cnt = pmv_cnt + 1;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_in);
    endtask

    task automatic send_local(input logic [7:0] m);
        local_move_valid = 1'b1;
        local_move = m;
        @(negedge clk_in);
        local_move_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] b);
        rx_ready = 1'b1;
        rx_data = b;
        @(negedge clk_in);
        rx_ready = 1'b0;
    endtask

    task automatic clear_log();
        trig_cyc.delete();
        trig_dat.delete();
    endtask

    task automatic test_reset();
        tick(3);
        checks++; if (local_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", local_busy); end
        checks++; if (link_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b want 0", link_err); end
        checks++; if (retry_count !== 2'd0) begin failures++; $display("FAIL reset_retry: got %0d want 0", retry_count); end
        checks++; if (tx_trigger !== 1'b0) begin failures++; $display("FAIL reset_trig: got %b want 0", tx_trigger); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL reset_txdata: got %h want 00", tx_data); end
        checks++; if ({local_done, peer_move_valid} !== 2'b00) begin failures++; $display("FAIL reset_pulses: got %b want 00", {local_done, peer_move_valid}); end
        checks++; if (peer_move !== 8'h00) begin failures++; $display("FAIL reset_peer_move: got %h want 00", peer_move); end
        rst_n_in = 1'b1;
        tick(3);
    endtask

    task automatic test_ack_path();
        clear_log();
        send_local(8'h34);
        checks++; if (tx_trigger !== 1'b1) begin failures++; $display("FAIL ack_path_trig: got %b want 1", tx_trigger); end
        checks++; if (tx_data !== 8'h34) begin failures++; $display("FAIL ack_path_data: got %h want 34", tx_data); end
        checks++; if (local_busy !== 1'b1) begin failures++; $display("FAIL ack_path_busy: got %b want 1", local_busy); end
        tick(28);
        send_rx(8'hFF);
        checks++; if (local_done !== 1'b1) begin failures++; $display("FAIL ack_path_done: got %b want 1", local_done); end
        checks++; if (local_busy !== 1'b0) begin failures++; $display("FAIL ack_path_idle: got %b want 0", local_busy); end
        checks++; if (retry_count !== 2'd0) begin failures++; $display("FAIL ack_path_retry: got %0d want 0", retry_count); end
        tick(1);
        checks++; if (local_done !== 1'b0) begin failures++; $display("FAIL ack_path_done_pulse: got %b want 0", local_done); end
        tick(30);
        checks++; if (trig_cyc.size() !== 1) begin failures++; $display("FAIL ack_path_trig_count: got %0d want 1", trig_cyc.size()); end
    endtask

    task automatic test_retry_err();
        int t0, err_cyc, n;
        clear_log();
        send_local(8'h56);
        t0 = cyc;
        err_cyc = -1;
        n = 0;
        while (link_err !== 1'b1 && n < 600) begin
            @(negedge clk_in);
            n++;
            if (cyc == t0 + 130) begin
                checks++; if (retry_count !== 2'd1) begin failures++; $display("FAIL retry_mid_count: got %0d want 1", retry_count); end
            end
        end
        if (link_err === 1'b1) err_cyc = cyc;
        // Byte k+1 goes out 20 (hold) + 100 (timeout) cycles after byte k; error 120 after the third.
        checks++; if (err_cyc !== t0 + 360) begin failures++; $display("FAIL retry_err_time: got %0d want %0d", err_cyc, t0 + 360); end
        checks++; if (trig_cyc.size() !== 3) begin failures++; $display("FAIL retry_trig_count: got %0d want 3", trig_cyc.size()); end
        checks++; if (trig_cyc[1] - trig_cyc[0] !== 120) begin failures++; $display("FAIL retry_gap1: got %0d want 120", trig_cyc[1] - trig_cyc[0]); end
        checks++; if (trig_cyc[2] - trig_cyc[0] !== 240) begin failures++; $display("FAIL retry_gap2: got %0d want 240", trig_cyc[2] - trig_cyc[0]); end
        checks++; if (trig_dat[2] !== 8'h56) begin failures++; $display("FAIL retry_data: got %h want 56", trig_dat[2]); end
        checks++; if (retry_count !== 2'd2) begin failures++; $display("FAIL retry_final_count: got %0d want 2", retry_count); end
        checks++; if (local_busy !== 1'b0) begin failures++; $display("FAIL retry_err_busy: got %b want 0", local_busy); end
        tick(5);
        send_local(8'h57);
        checks++; if (link_err !== 1'b0) begin failures++; $display("FAIL err_recover_clear: got %b want 0", link_err); end
        checks++; if (retry_count !== 2'd0) begin failures++; $display("FAIL err_recover_retry: got %0d want 0", retry_count); end
        checks++; if (tx_data !== 8'h57) begin failures++; $display("FAIL err_recover_data: got %h want 57", tx_data); end
        tick(5);
        send_rx(8'hFF);
        checks++; if (local_done !== 1'b1) begin failures++; $display("FAIL err_recover_done: got %b want 1", local_done); end
        tick(30);
    endtask

    task automatic test_dedupe();
        int pmv_before;
        clear_log();
        pmv_before = pmv_cnt;
        peer_turn = 1'b1;
        tick(1);
        send_rx(8'h52);
        checks++; if (peer_move_valid !== 1'b1) begin failures++; $display("FAIL dedupe_valid: got %b want 1", peer_move_valid); end
        checks++; if (peer_move !== 8'h52) begin failures++; $display("FAIL dedupe_move: got %h want 52", peer_move); end
        checks++; if (tx_data !== 8'hFF || tx_trigger !== 1'b1) begin failures++; $display("FAIL dedupe_ack1: got %b/%h want 1/ff", tx_trigger, tx_data); end
        tick(4);
        send_rx(8'h52);
        tick(30);
        checks++; if (pmv_cnt - pmv_before !== 1) begin failures++; $display("FAIL dedupe_count: got %0d want 1", pmv_cnt - pmv_before); end
        checks++; if (trig_cyc.size() !== 2) begin failures++; $display("FAIL dedupe_acks: got %0d want 2", trig_cyc.size()); end
        checks++; if (trig_cyc[1] - trig_cyc[0] !== 20 || trig_dat[1] !== 8'hFF) begin failures++; $display("FAIL dedupe_ack2: got gap %0d data %h want 20 ff", trig_cyc[1] - trig_cyc[0], trig_dat[1]); end
        checks++; if (peer_move !== 8'h52) begin failures++; $display("FAIL dedupe_hold: got %h want 52", peer_move); end
        peer_turn = 1'b0;
        tick(5);
    endtask

    task automatic test_back_to_back();
        int n, pmv_before;
        clear_log();
        pmv_before = pmv_cnt;
        rx_ready = 1'b1; rx_data = 8'h21;
        local_move_valid = 1'b1; local_move = 8'h44;
        @(negedge clk_in);
        rx_ready = 1'b0; local_move_valid = 1'b0;
        checks++; if (tx_trigger !== 1'b1 || tx_data !== 8'hFF) begin failures++; $display("FAIL b2b_ack_first: got %b/%h want 1/ff", tx_trigger, tx_data); end
        n = 0;
        while (trig_cyc.size() < 3 && n < 400) begin @(negedge clk_in); n++; end
        checks++; if (trig_cyc.size() < 3) begin failures++; $display("FAIL b2b_timeout: got %0d triggers want 3", trig_cyc.size()); end
        checks++; if (trig_cyc[1] - trig_cyc[0] !== 20 || trig_dat[1] !== 8'h44) begin failures++; $display("FAIL b2b_move: got gap %0d data %h want 20 44", trig_cyc[1] - trig_cyc[0], trig_dat[1]); end
        // Timer starts after the move byte: 20 + 20 + 100 from the ACK byte.
        checks++; if (trig_cyc[2] - trig_cyc[0] !== 140 || trig_dat[2] !== 8'h44) begin failures++; $display("FAIL b2b_resend: got gap %0d data %h want 140 44", trig_cyc[2] - trig_cyc[0], trig_dat[2]); end
        checks++; if (retry_count !== 2'd1) begin failures++; $display("FAIL b2b_retry: got %0d want 1", retry_count); end
        checks++; if (pmv_cnt !== pmv_before) begin failures++; $display("FAIL b2b_no_delivery: got %0d want %0d", pmv_cnt, pmv_before); end
        tick(5);
        send_rx(8'hFF);
        checks++; if (local_done !== 1'b1) begin failures++; $display("FAIL b2b_done: got %b want 1", local_done); end
        tick(30);
    endtask

    task automatic test_ack_on_timeout();
        int t;
        clear_log();
        send_local(8'h66);
        t = cyc;
        while (cyc < t + 119) @(negedge clk_in);
        // This cycle the ACK timer sits at zero: timeout and ACK coincide.
        send_rx(8'hFF);
        checks++; if (local_done !== 1'b1) begin failures++; $display("FAIL tmo_ack_done: got %b want 1", local_done); end
        checks++; if (tx_trigger !== 1'b0) begin failures++; $display("FAIL tmo_ack_no_resend: got %b want 0", tx_trigger); end
        checks++; if (retry_count !== 2'd0) begin failures++; $display("FAIL tmo_ack_retry: got %0d want 0", retry_count); end
        tick(200);
        checks++; if (trig_cyc.size() !== 1) begin failures++; $display("FAIL tmo_ack_trig_count: got %0d want 1", trig_cyc.size()); end
        checks++; if (local_busy !== 1'b0) begin failures++; $display("FAIL tmo_ack_idle: got %b want 0", local_busy); end
    endtask

    task automatic test_async_reset();
        send_local(8'h77);
        tick(50);
        #2 rst_n_in = 1'b0;
        #1;
        checks++; if (local_busy !== 1'b0) begin failures++; $display("FAIL arst_busy: got %b want 0", local_busy); end
        checks++; if (tx_data !== 8'h00) begin failures++; $display("FAIL arst_txdata: got %h want 00", tx_data); end
        checks++; if (peer_move !== 8'h00) begin failures++; $display("FAIL arst_peer_move: got %h want 00", peer_move); end
        checks++; if ({link_err, retry_count, tx_trigger} !== 4'b0) begin failures++; $display("FAIL arst_misc: got %b want 0000", {link_err, retry_count, tx_trigger}); end
        @(negedge clk_in);
        rst_n_in = 1'b1;
        clear_log();
        tick(300);
        checks++; if (trig_cyc.size() !== 0) begin failures++; $display("FAIL arst_spurious_tx: got %0d want 0", trig_cyc.size()); end
        checks++; if (local_busy !== 1'b0) begin failures++; $display("FAIL arst_idle: got %b want 0", local_busy); end
    endtask

    initial begin
        test_reset();
        test_ack_path();
        test_retry_err();
        test_dedupe();
        test_back_to_back();
        test_ack_on_timeout();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
